// File: rtl/frame_buffer_swapper_pkg.sv
// Shared types and constants for the ping-pong frame store: scan FSM encoding,
// default frame geometry and the RGB565 byte packing helper.
package frame_buffer_swapper_pkg;

  localparam int   DEF_BUF_X  = 4;
  localparam int   DEF_BUF_Y  = 3;
  localparam logic ACK        = 1'b1;
  localparam int   PIX_HI_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_HI,
    S_RD_LO,
    S_PRESENT
  } scan_state_e;

  // Byte 2n carries the upper half of the RGB565 word, byte 2n+1 the lower.
  function automatic logic [15:0] pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return (16'(hi) << PIX_HI_LSB) | 16'(lo);
  endfunction

endpackage

// File: rtl/frame_buffer_swapper_fb_bank_ram.sv
// One frame bank: byte-wide storage with one write port and one synchronous
// read port (read data appears the cycle after the address).
module fb_bank_ram #(
  parameter int DEPTH = 24,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_swapper.sv
// Ping-pong frame store: byte writes land in the back bank, the front bank is
// scanned out as RGB565 pixels, and banks swap only between frames.
//
//  state     | meaning
//  S_IDLE    | between frames; pending swap executes here; scan_en starts a frame
//  S_RD_HI   | read address 2n (high byte) issued to the front bank
//  S_RD_LO   | read address 2n+1 issued, high byte captured
//  S_PRESENT | low byte captured, pixel held on pix_* until accepted
module frame_buffer_swapper
  import frame_buffer_swapper_pkg::*;
#(
  parameter  int IMAGE_BUF_X    = DEF_BUF_X,
  parameter  int IMAGE_BUF_Y    = DEF_BUF_Y,
  localparam int IMAGE_BUF_SIZE = IMAGE_BUF_X * IMAGE_BUF_Y * 2,
  localparam int AW             = $clog2(IMAGE_BUF_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_req,
  input  logic [31:0]   mem_addr,
  input  logic [7:0]    mem_in,
  output logic          mem_ready,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          front_sel,
  input  logic          scan_en,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [15:0]   pix_data,
  output logic [AW-1:0] pix_x,
  output logic [AW-1:0] pix_y,
  output logic          frame_start,
  output logic          addr_err
);

  scan_state_e   state;
  logic          swap_req_q;
  logic          swap_pending;
  logic          armed;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] cx;
  logic [AW-1:0] cy;
  logic [7:0]    hi_byte;

  logic          swap_rise;
  logic          swap_go;
  logic          wr_go;
  logic          addr_bad;
  logic          we0;
  logic          we1;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata0;
  logic [7:0]    rdata1;
  logic [7:0]    rd_data;
  logic          last_px;

  assign swap_rise = swap_req & ~swap_req_q;
  assign swap_go   = (swap_rise | swap_pending) & (state == S_IDLE);
  // A swap being requested or executed this cycle holds off the write by a cycle.
  assign wr_go     = armed & mem_req & ~swap_pending & ~swap_rise;
  assign addr_bad  = mem_addr >= 32'(IMAGE_BUF_SIZE);
  assign we0       = wr_go & ~addr_bad & front_sel;
  assign we1       = wr_go & ~addr_bad & ~front_sel;
  assign raddr     = (state == S_RD_LO) ? rd_ptr + AW'(1) : rd_ptr;
  assign rd_data   = front_sel ? rdata1 : rdata0;
  assign last_px   = (cx == AW'(IMAGE_BUF_X - 1)) && (cy == AW'(IMAGE_BUF_Y - 1));

  fb_bank_ram #(.DEPTH(IMAGE_BUF_SIZE), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (mem_addr[AW-1:0]),
    .wdata (mem_in),
    .re    (~front_sel),
    .raddr (raddr),
    .rdata (rdata0)
  );

  fb_bank_ram #(.DEPTH(IMAGE_BUF_SIZE), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (mem_addr[AW-1:0]),
    .wdata (mem_in),
    .re    (front_sel),
    .raddr (raddr),
    .rdata (rdata1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_req_q   <= 1'b0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      swap_done    <= 1'b0;
      armed        <= 1'b1;
      mem_ready    <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      swap_req_q <= swap_req;
      swap_done  <= swap_go;
      mem_ready  <= wr_go ? ACK : ~ACK;
      if (swap_go) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_rise) begin
        swap_pending <= 1'b1;
      end
      // One write per mem_req high period; re-arm once the request drops.
      if (wr_go)         armed <= 1'b0;
      else if (!mem_req) armed <= 1'b1;
      if (wr_go && addr_bad) addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      cx          <= '0;
      cy          <= '0;
      hi_byte     <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (scan_en) state <= S_RD_HI;
        end
        S_RD_HI: begin
          state <= S_RD_LO;
        end
        S_RD_LO: begin
          hi_byte <= rd_data;
          state   <= S_PRESENT;
        end
        S_PRESENT: begin
          if (!pix_valid) begin
            pix_valid   <= 1'b1;
            pix_data    <= pack_rgb565(hi_byte, rd_data);
            pix_x       <= cx;
            pix_y       <= cy;
            frame_start <= (cx == '0) && (cy == '0);
          end else if (pix_ready) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (last_px) begin
              rd_ptr <= '0;
              cx     <= '0;
              cy     <= '0;
              state  <= S_IDLE;
            end else begin
              rd_ptr <= rd_ptr + AW'(2);
              if (cx == AW'(IMAGE_BUF_X - 1)) begin
                cx <= '0;
                cy <= cy + AW'(1);
              end else begin
                cx <= cx + AW'(1);
              end
              state <= S_RD_HI;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_swapper.sv
// Directed bench for frame_buffer_swapper (4x3 frame, 24 bytes per bank).
module tb_frame_buffer_swapper;

  localparam int NPIX = 12;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [7:0]    mem_in;
  logic          mem_ready;
  logic          swap_req;
  logic          swap_done;
  logic          front_sel;
  logic          scan_en;
  logic          pix_valid;
  logic          pix_ready;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_x;
  logic [AW-1:0] pix_y;
  logic          frame_start;
  logic          addr_err;

  int total = 0;
  int bad   = 0;

  logic [15:0]   cap_data [16];
  int            cap_x [16];
  int            cap_y [16];
  logic          cap_fs [16];
  int            n_cap;
  int            first_valid_tick;
  int            last_acc_tick;
  int            swap_done_tick;
  int            ready_tick;
  int            front_change_tick;
  int            stall_bad;
  logic [15:0]   held_data;
  logic [AW-1:0] held_x;
  logic [AW-1:0] held_y;
  bit            timed_out;

  frame_buffer_swapper dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_in      (mem_in),
    .mem_ready   (mem_ready),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .front_sel   (front_sel),
    .scan_en     (scan_en),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [31:0] a, input logic [7:0] d, output bit acked);
    acked    = 1'b0;
    mem_addr = a;
    mem_in   = d;
    mem_req  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_ready) begin
        acked = 1'b1;
        break;
      end
    end
    mem_req = 1'b0;
    tick();
  endtask

  // Runs one frame with pix_ready high, optionally stalling one pixel and
  // raising swap_req plus a write request when a given pixel is presented.
  task automatic scan_frame(input int stall_px, input int stall_len, input int swap_px, input int run_after);
    int   t;
    bit   stalled;
    bit   swap_clr;
    logic fs0;
    for (int i = 0; i < 16; i++) begin
      cap_data[i] = 16'hxxxx;
      cap_x[i]    = -1;
      cap_y[i]    = -1;
      cap_fs[i]   = 1'bx;
    end
    n_cap = 0; first_valid_tick = -1; last_acc_tick = -1; swap_done_tick = -1;
    ready_tick = -1; front_change_tick = -1; stall_bad = 0; timed_out = 1'b1;
    stalled = 1'b0; swap_clr = 1'b0; fs0 = front_sel;
    scan_en = 1'b1; pix_ready = 1'b1; t = 0;
    while (t < 400) begin
      tick(); t++;
      if (t == 1) scan_en = 1'b0;
      if (swap_clr) begin swap_req = 1'b0; swap_clr = 1'b0; end
      if (swap_done && swap_done_tick < 0) swap_done_tick = t;
      if (front_sel !== fs0 && front_change_tick < 0) front_change_tick = t;
      if (mem_ready && ready_tick < 0) begin ready_tick = t; mem_req = 1'b0; end
      if (pix_valid && n_cap < NPIX) begin
        if (first_valid_tick < 0) first_valid_tick = t;
        if (n_cap == stall_px && !stalled) begin
          stalled = 1'b1; pix_ready = 1'b0;
          held_data = pix_data; held_x = pix_x; held_y = pix_y;
          for (int k = 0; k < stall_len; k++) begin
            tick(); t++;
            if (!pix_valid || pix_data !== held_data || pix_x !== held_x || pix_y !== held_y) stall_bad++;
          end
          pix_ready = 1'b1;
        end
        cap_data[n_cap] = pix_data;
        cap_x[n_cap]    = int'(pix_x);
        cap_y[n_cap]    = int'(pix_y);
        cap_fs[n_cap]   = frame_start;
        if (n_cap == swap_px) begin
          swap_req = 1'b1; swap_clr = 1'b1;
          mem_addr = 32'd0; mem_in = 8'hAA; mem_req = 1'b1;
        end
        n_cap++;
        if (n_cap == NPIX) last_acc_tick = t + 1;
      end
      if (n_cap == NPIX && t >= last_acc_tick + run_after) begin
        timed_out = 1'b0;
        break;
      end
    end
    scan_en = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({mem_ready, swap_done, front_sel, pix_valid, frame_start, addr_err} !== 6'b0 ||
        pix_data !== 16'h0 || pix_x !== '0 || pix_y !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ctl=%b data=%h x=%0d y=%0d want all zero",
               {mem_ready, swap_done, front_sel, pix_valid, frame_start, addr_err}, pix_data, pix_x, pix_y);
    end
    reset = 1'b0;
    tick(); tick();
    total++;
    if (mem_ready !== 1'b0 || pix_valid !== 1'b0 || swap_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got ready=%b valid=%b swap_done=%b want 0 0 0", mem_ready, pix_valid, swap_done);
    end
  endtask

  task automatic test_fill_and_swap();
    int acks;
    bit ok;
    acks = 0;
    for (int a = 0; a < 24; a++) begin
      write_byte(32'(a), 8'(a), ok);
      if (ok) acks++;
    end
    total++;
    if (acks != 24) begin bad++; $display("FAIL fill_acks: got %0d want 24", acks); end
    total++;
    if (addr_err !== 1'b0) begin bad++; $display("FAIL fill_addr_err: got %b want 0", addr_err); end
    swap_req = 1'b1;
    tick();
    total++;
    if (swap_done !== 1'b1 || front_sel !== 1'b1) begin
      bad++; $display("FAIL idle_swap: got swap_done=%b front_sel=%b want 1 1", swap_done, front_sel);
    end
    swap_req = 1'b0;
    tick();
    total++;
    if (swap_done !== 1'b0 || front_sel !== 1'b1) begin
      bad++; $display("FAIL swap_pulse_end: got swap_done=%b front_sel=%b want 0 1", swap_done, front_sel);
    end
  endtask

  task automatic test_scan_frame();
    logic [15:0] e;
    scan_frame(-1, 0, -1, 2);
    total++;
    if (timed_out || n_cap != NPIX) begin bad++; $display("FAIL frame1_count: got %0d timeout=%b want 12", n_cap, timed_out); end
    total++;
    if (first_valid_tick != 4) begin bad++; $display("FAIL frame1_latency: got %0d want 4", first_valid_tick); end
    for (int n = 0; n < NPIX; n++) begin
      e = {8'(2 * n), 8'(2 * n + 1)};
      total++;
      if (cap_data[n] !== e) begin bad++; $display("FAIL frame1_pix%0d: got %h want %h", n, cap_data[n], e); end
      total++;
      if (cap_x[n] != n % 4 || cap_y[n] != n / 4 || cap_fs[n] !== (n == 0)) begin
        bad++;
        $display("FAIL frame1_xy%0d: got x=%0d y=%0d fs=%b want x=%0d y=%0d fs=%b",
                 n, cap_x[n], cap_y[n], cap_fs[n], n % 4, n / 4, (n == 0));
      end
    end
    total++;
    if (swap_done_tick >= 0 || front_sel !== 1'b1) begin
      bad++; $display("FAIL frame1_no_swap: got swap_tick=%0d front=%b want -1 1", swap_done_tick, front_sel);
    end
  endtask

  task automatic test_swap_mid_frame();
    bit ok;
    int acks;
    logic [15:0] e;
    acks = 0;
    for (int a = 0; a < 24; a++) begin
      write_byte(32'(a), 8'(a + 8'h40), ok);
      if (ok) acks++;
    end
    total++;
    if (acks != 24) begin bad++; $display("FAIL fill0_acks: got %0d want 24", acks); end
    scan_frame(-1, 0, 5, 4);
    total++;
    if (timed_out || n_cap != NPIX) begin bad++; $display("FAIL swapframe_count: got %0d timeout=%b want 12", n_cap, timed_out); end
    for (int n = 0; n < NPIX; n++) begin
      e = {8'(2 * n), 8'(2 * n + 1)};
      total++;
      if (cap_data[n] !== e) begin bad++; $display("FAIL swapframe_pix%0d: got %h want %h", n, cap_data[n], e); end
    end
    total++;
    if (swap_done_tick != last_acc_tick + 1) begin
      bad++; $display("FAIL swap_timing: got tick %0d want %0d", swap_done_tick, last_acc_tick + 1);
    end
    total++;
    if (front_change_tick != swap_done_tick) begin
      bad++; $display("FAIL front_toggle_tick: got %0d want %0d", front_change_tick, swap_done_tick);
    end
    total++;
    if (ready_tick != swap_done_tick + 1) begin
      bad++; $display("FAIL held_write_ack: got tick %0d want %0d", ready_tick, swap_done_tick + 1);
    end
    total++;
    if (front_sel !== 1'b0) begin bad++; $display("FAIL swap_front: got %b want 0", front_sel); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    scan_frame(7, 10, -1, 2);
    total++;
    if (timed_out || n_cap != NPIX) begin bad++; $display("FAIL bp_count: got %0d timeout=%b want 12", n_cap, timed_out); end
    total++;
    if (stall_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
    total++;
    if (held_data !== 16'h4E4F || held_x !== 5'd3 || held_y !== 5'd1) begin
      bad++; $display("FAIL bp_held: got %h (%0d,%0d) want 4e4f (3,1)", held_data, held_x, held_y);
    end
    for (int n = 0; n < NPIX; n++) begin
      e = {8'(8'h40 + 2 * n), 8'(8'h41 + 2 * n)};
      total++;
      if (cap_data[n] !== e || cap_x[n] != n % 4 || cap_y[n] != n / 4) begin
        bad++;
        $display("FAIL bp_pix%0d: got %h (%0d,%0d) want %h (%0d,%0d)", n, cap_data[n], cap_x[n], cap_y[n], e, n % 4, n / 4);
      end
    end
  endtask

  task automatic test_addr_err();
    bit ok;
    logic [15:0] e;
    write_byte(32'd24, 8'hEE, ok);
    total++;
    if (!ok || addr_err !== 1'b1) begin bad++; $display("FAIL oob24: got ack=%b err=%b want 1 1", ok, addr_err); end
    write_byte(32'hFFFF_FFFF, 8'hEE, ok);
    total++;
    if (!ok || addr_err !== 1'b1) begin bad++; $display("FAIL oob_max: got ack=%b err=%b want 1 1", ok, addr_err); end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    total++;
    if (swap_done !== 1'b1 || front_sel !== 1'b1) begin
      bad++; $display("FAIL err_swap: got swap_done=%b front=%b want 1 1", swap_done, front_sel);
    end
    tick();
    scan_frame(-1, 0, -1, 2);
    for (int n = 0; n < NPIX; n++) begin
      e = (n == 0) ? 16'hAA01 : {8'(2 * n), 8'(2 * n + 1)};
      total++;
      if (cap_data[n] !== e) begin bad++; $display("FAIL err_frame_pix%0d: got %h want %h", n, cap_data[n], e); end
    end
    total++;
    if (addr_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", addr_err); end
  endtask

  task automatic test_reset_mid_frame();
    scan_en = 1'b1; pix_ready = 1'b1;
    tick();
    scan_en = 1'b0;
    repeat (13) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    total++;
    if (front_sel !== 1'b1 || swap_done !== 1'b0) begin
      bad++; $display("FAIL midframe_pending: got front=%b swap_done=%b want 1 0", front_sel, swap_done);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({mem_ready, swap_done, front_sel, pix_valid, frame_start, addr_err} !== 6'b0 ||
        pix_data !== 16'h0 || pix_x !== '0 || pix_y !== '0) begin
      bad++;
      $display("FAIL midframe_reset: got ctl=%b data=%h x=%0d y=%0d want all zero",
               {mem_ready, swap_done, front_sel, pix_valid, frame_start, addr_err}, pix_data, pix_x, pix_y);
    end
    tick();
    reset = 1'b0;
    tick();
    scan_frame(-1, 0, -1, 3);
    total++;
    if (timed_out || n_cap != NPIX) begin bad++; $display("FAIL restart_count: got %0d timeout=%b want 12", n_cap, timed_out); end
    total++;
    if (cap_x[0] != 0 || cap_y[0] != 0 || cap_fs[0] !== 1'b1 || cap_x[11] != 3 || cap_y[11] != 2) begin
      bad++;
      $display("FAIL restart_xy: got first (%0d,%0d) fs=%b last (%0d,%0d) want (0,0) 1 (3,2)",
               cap_x[0], cap_y[0], cap_fs[0], cap_x[11], cap_y[11]);
    end
    total++;
    if (swap_done_tick >= 0 || front_sel !== 1'b0) begin
      bad++; $display("FAIL pending_lost: got swap_tick=%0d front=%b want -1 0", swap_done_tick, front_sel);
    end
  endtask

  initial begin
    reset = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_in = '0;
    swap_req = 1'b0; scan_en = 1'b0; pix_ready = 1'b0;
    #12;
    test_reset();
    test_fill_and_swap();
    test_scan_frame();
    test_swap_mid_frame();
    test_backpressure();
    test_addr_err();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
